// File: rtl/result_frame_tx.sv
// Serialises each captured localisation result as a 15-byte 8N1 UART frame:
// sync, status, P, Q, R (MSB first), XOR checksum of bytes 1..13.
module result_frame_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        Gbl_CLK,
  input  logic        RST_EX_N,
  input  logic        Result_Ready,
  input  logic [31:0] P,
  input  logic [31:0] Q,
  input  logic [31:0] R,
  input  logic [1:0]  Quadrent,
  input  logic        Flag_ERR,
  input  logic        Flag_CNT,
  input  logic        Flag_DIAG,
  input  logic        Flag_MED,
  output logic        TX_OUT,
  output logic        TX_BUSY,
  output logic        Frame_Done,
  output logic        Pend_Full,
  output logic [7:0]  OVR_CNT
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t             state;
  logic               rr_q;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_idx;
  logic [3:0]         byte_idx;
  logic [103:0]       active_snap;
  logic [103:0]       pend_snap;
  logic               pend_valid;
  logic [7:0]         ovr_cnt;

  logic               capture;
  logic               bit_end;
  logic               in_frame;
  logic [103:0]       snap_in;
  logic [7:0]         body [13];
  logic [7:0]         csum;
  logic [7:0]         cur_byte;

  assign capture  = Result_Ready & ~rr_q;
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign in_frame = (state == START) || (state == DATA) || (state == STOP);
  // Snapshot is stored already formatted as the status byte plus P, Q, R.
  assign snap_in  = {Flag_ERR, Flag_CNT, Flag_DIAG, Flag_MED, 2'b00, Quadrent, P, Q, R};

  genvar gi;
  generate
    for (gi = 0; gi < 13; gi++) begin : g_body
      assign body[gi] = active_snap[103 - 8*gi -: 8];
    end
  endgenerate

  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < 13; i++) csum = csum ^ body[i];
  end

  always_comb begin
    cur_byte = csum;
    if (byte_idx == 4'd0)
      cur_byte = SYNC_BYTE;
    else if (byte_idx < 4'd14)
      cur_byte = body[byte_idx - 4'd1];
  end

  assign Pend_Full = pend_valid;
  assign OVR_CNT   = ovr_cnt;

  always_ff @(posedge Gbl_CLK or negedge RST_EX_N) begin
    if (!RST_EX_N) begin
      state       <= IDLE;
      rr_q        <= 1'b1;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      active_snap <= '0;
      pend_snap   <= '0;
      pend_valid  <= 1'b0;
      ovr_cnt     <= '0;
      TX_OUT      <= 1'b1;
      TX_BUSY     <= 1'b0;
      Frame_Done  <= 1'b0;
    end else begin
      rr_q       <= Result_Ready;
      TX_BUSY    <= in_frame;
      Frame_Done <= (state == DONE);
      case (state)
        START:   TX_OUT <= 1'b0;
        DATA:    TX_OUT <= cur_byte[bit_idx];
        default: TX_OUT <= 1'b1;
      endcase

      case (state)
        IDLE, DONE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          if (pend_valid) begin
            active_snap <= pend_snap;
            state       <= START;
            if (capture) pend_snap  <= snap_in;
            else         pend_valid <= 1'b0;
          end else if (capture) begin
            active_snap <= snap_in;
            state       <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_idx == 4'd14) begin
              state <= DONE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // While on the line, one snapshot may wait; anything beyond that is dropped.
      if (capture && in_frame) begin
        if (!pend_valid) begin
          pend_snap  <= snap_in;
          pend_valid <= 1'b1;
        end else if (ovr_cnt != 8'hFF) begin
          ovr_cnt <= ovr_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_frame_tx.sv
// Directed bench for result_frame_tx with CLKS_PER_BIT=4: a UART monitor
// decodes TX_OUT while one linear initial block applies the scenarios.
module tb_result_frame_tx;

  logic        Gbl_CLK;
  logic        RST_EX_N;
  logic        Result_Ready;
  logic [31:0] P, Q, R;
  logic [1:0]  Quadrent;
  logic        Flag_ERR, Flag_CNT, Flag_DIAG, Flag_MED;
  logic        TX_OUT, TX_BUSY, Frame_Done, Pend_Full;
  logic [7:0]  OVR_CNT;

  result_frame_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut (
    .Gbl_CLK(Gbl_CLK), .RST_EX_N(RST_EX_N), .Result_Ready(Result_Ready),
    .P(P), .Q(Q), .R(R), .Quadrent(Quadrent),
    .Flag_ERR(Flag_ERR), .Flag_CNT(Flag_CNT), .Flag_DIAG(Flag_DIAG), .Flag_MED(Flag_MED),
    .TX_OUT(TX_OUT), .TX_BUSY(TX_BUSY), .Frame_Done(Frame_Done),
    .Pend_Full(Pend_Full), .OVR_CNT(OVR_CNT)
  );

  initial Gbl_CLK = 1'b0;
  always #5 Gbl_CLK = ~Gbl_CLK;

  int cyc = 0;
  always @(posedge Gbl_CLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int frame_err = 0;
  int bad_done = 0;
  int cap_cyc = 0;
  logic [7:0] rx_q[$];
  int         bs_q[$];
  int         done_q[$];

  localparam logic [119:0] FRAME_A = 120'hA5_22_00000001_00000002_00000003_22;
  localparam logic [119:0] FRAME_B = 120'hA5_91_DEADBEEF_01234567_89ABCDEF_B3;
  localparam logic [119:0] FRAME_C = 120'hA5_00_11111111_00000000_00000000_00;
  localparam logic [119:0] FRAME_D = 120'hA5_43_00000010_00000020_00000030_43;
  localparam logic [119:0] FRAME_E = 120'hA5_80_01020304_00000000_00000000_84;
  localparam logic [119:0] FRAME_F = 120'hA5_01_00000000_00000000_000000FF_FE;

  // UART monitor: samples mid-bit on falling clock edges, aborts on reset.
  initial begin
    logic [7:0] sh;
    int cnt;
    int st;
    bit busy;
    bit last_done;
    sh = 8'h00; cnt = 0; st = 0; busy = 0; last_done = 0;
    forever begin
      @(negedge Gbl_CLK);
      if (RST_EX_N !== 1'b1) begin
        busy = 0;
        last_done = 0;
      end else begin
        if (Frame_Done === 1'b1) begin
          done_q.push_back(cyc);
          if (TX_OUT !== 1'b1 || TX_BUSY !== 1'b0 || last_done) bad_done++;
        end
        last_done = (Frame_Done === 1'b1);
        if (!busy) begin
          if (TX_OUT === 1'b0) begin
            busy = 1; cnt = 0; st = cyc;
          end
        end else begin
          cnt++;
          if (cnt == 2 && TX_OUT !== 1'b0) frame_err++;
          if (cnt >= 6 && cnt <= 34 && ((cnt - 2) % 4) == 0) sh[(cnt - 6) / 4] = TX_OUT;
          if (cnt == 38) begin
            if (TX_OUT !== 1'b1) frame_err++;
            rx_q.push_back(sh);
            bs_q.push_back(st);
            busy = 0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int base, input logic [119:0] f);
    logic [7:0] got;
    for (int i = 0; i < 15; i++) begin
      got = (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, f[119 - 8*i -: 8]});
    end
    $display("frame %s checked from byte %0d", tag, base);
  endtask

  task automatic pulse(input logic [31:0] p, input logic [31:0] q, input logic [31:0] r,
                       input logic [1:0] qd, input logic [3:0] fl);
    @(negedge Gbl_CLK);
    P = p; Q = q; R = r; Quadrent = qd;
    {Flag_ERR, Flag_CNT, Flag_DIAG, Flag_MED} = fl;
    Result_Ready = 1'b1;
    cap_cyc = cyc + 1;
    @(negedge Gbl_CLK);
    Result_Ready = 1'b0;
  endtask

  task automatic wait_dones(input string tag, input int k, input int budget);
    int n;
    n = 0;
    while (done_q.size() < k && n < budget) begin
      @(negedge Gbl_CLK);
      n++;
    end
    check(tag, done_q.size(), k);
  endtask

  task automatic clear_logs();
    rx_q.delete();
    bs_q.delete();
    done_q.delete();
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge Gbl_CLK);
  endtask

  initial begin
    int t0;
    int capd;
    int n;
    RST_EX_N = 1'b0; Result_Ready = 1'b0;
    P = '0; Q = '0; R = '0; Quadrent = '0;
    Flag_ERR = 0; Flag_CNT = 0; Flag_DIAG = 0; Flag_MED = 0;
    skip(3);
    check("rst_tx", TX_OUT, 1);
    check("rst_busy", TX_BUSY, 0);
    check("rst_done", Frame_Done, 0);
    check("rst_pend", Pend_Full, 0);
    check("rst_ovr", OVR_CNT, 0);
    RST_EX_N = 1'b1;
    skip(3);

    // Single frame: latency, content, Frame_Done timing.
    pulse(32'd1, 32'd2, 32'd3, 2'b10, 4'b0010);
    @(negedge Gbl_CLK);
    check("t1_busy", TX_BUSY, 1);
    check("t1_start", TX_OUT, 0);
    wait_dones("t1_dones", 1, 800);
    check("t1_start_lat", (bs_q.size() > 0) ? bs_q[0] - cap_cyc : -1, 1);
    check("t1_done_lat", (done_q.size() > 0) ? done_q[0] - cap_cyc : -1, 601);
    @(negedge Gbl_CLK);
    check("t1_done_width", Frame_Done, 0);
    check("t1_nbytes", rx_q.size(), 15);
    check_frame("t1", 0, FRAME_A);
    clear_logs();

    // Level held high: one capture only.
    @(negedge Gbl_CLK);
    P = 32'hDEADBEEF; Q = 32'h01234567; R = 32'h89ABCDEF; Quadrent = 2'b01;
    {Flag_ERR, Flag_CNT, Flag_DIAG, Flag_MED} = 4'b1001;
    Result_Ready = 1'b1;
    skip(1000);
    Result_Ready = 1'b0;
    skip(700);
    check("t2_dones", done_q.size(), 1);
    check("t2_nbytes", rx_q.size(), 15);
    check("t2_ovr", OVR_CNT, 0);
    check_frame("t2", 0, FRAME_B);
    clear_logs();

    // Three captures in one frame: one pending, one dropped.
    pulse(32'd1, 32'd2, 32'd3, 2'b10, 4'b0010);
    skip(50);
    pulse(32'h11111111, 32'd0, 32'd0, 2'b00, 4'b0000);
    check("t3_pend", Pend_Full, 1);
    skip(50);
    pulse(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 4'b1111);
    check("t3_ovr_now", OVR_CNT, 1);
    check("t3_pend_kept", Pend_Full, 1);
    wait_dones("t3_dones", 2, 1500);
    check("t3_done_gap", (done_q.size() > 1) ? done_q[1] - done_q[0] : -1, 601);
    check("t3_idle_gap", (bs_q.size() > 15) ? bs_q[15] - bs_q[14] : -1, 41);
    check("t3_nbytes", rx_q.size(), 30);
    check_frame("t3a", 0, FRAME_A);
    check_frame("t3b", 15, FRAME_C);
    check("t3_ovr", OVR_CNT, 1);
    check("t3_pend_end", Pend_Full, 0);

    // Reset with Result_Ready already high must not capture.
    @(negedge Gbl_CLK);
    RST_EX_N = 1'b0;
    Result_Ready = 1'b1;
    skip(3);
    RST_EX_N = 1'b1;
    clear_logs();
    skip(10);
    check("rr_high_busy", TX_BUSY, 0);
    check("rr_high_tx", TX_OUT, 1);
    check("rst_ovr_clear", OVR_CNT, 0);
    Result_Ready = 1'b0;

    // Capture on the DONE cycle while pending is full.
    pulse(32'h10, 32'h20, 32'h30, 2'b11, 4'b0100);
    capd = cap_cyc;
    skip(40);
    pulse(32'h01020304, 32'd0, 32'd0, 2'b00, 4'b1000);
    n = 0;
    while (cyc + 2 != capd + 601 && n < 1000) begin
      @(negedge Gbl_CLK);
      n++;
    end
    pulse(32'd0, 32'd0, 32'h000000FF, 2'b01, 4'b0000);
    check("t4_pend_refill", Pend_Full, 1);
    wait_dones("t4_dones", 3, 2500);
    check("t4_nbytes", rx_q.size(), 45);
    check_frame("t4d", 0, FRAME_D);
    check_frame("t4e", 15, FRAME_E);
    check_frame("t4f", 30, FRAME_F);
    check("t4_gap2", (bs_q.size() > 30) ? bs_q[30] - bs_q[29] : -1, 41);
    check("t4_ovr", OVR_CNT, 0);
    clear_logs();

    // Reset during byte 7 with a snapshot pending.
    pulse(32'd1, 32'd2, 32'd3, 2'b10, 4'b0010);
    t0 = cap_cyc;
    skip(20);
    pulse(32'h11111111, 32'd0, 32'd0, 2'b00, 4'b0000);
    n = 0;
    while (cyc != t0 + 299 && n < 1000) begin
      @(negedge Gbl_CLK);
      n++;
    end
    check("t5_pre_tx", TX_OUT, 0);
    check("t5_pre_pend", Pend_Full, 1);
    RST_EX_N = 1'b0;
    #1;
    check("t5_async_tx", TX_OUT, 1);
    check("t5_async_pend", Pend_Full, 0);
    check("t5_async_busy", TX_BUSY, 0);
    skip(4);
    RST_EX_N = 1'b1;
    clear_logs();
    skip(700);
    check("t5_no_done", done_q.size(), 0);
    check("t5_no_bytes", rx_q.size(), 0);
    pulse(32'd1, 32'd2, 32'd3, 2'b10, 4'b0010);
    wait_dones("t5_dones", 1, 800);
    check("t5_done_lat", (done_q.size() > 0) ? done_q[0] - cap_cyc : -1, 601);
    check_frame("t5", 0, FRAME_A);
    clear_logs();

    // Overrun saturation while continuously busy.
    for (int k = 1; k <= 150; k++) pulse(k, 32'd0, 32'd0, 2'b00, 4'b0000);
    check("t6_ovr_mid", OVR_CNT, 148);
    for (int k = 151; k <= 300; k++) pulse(k, 32'd0, 32'd0, 2'b00, 4'b0000);
    check("t6_ovr_sat", OVR_CNT, 255);
    wait_dones("t6_dones", 2, 1500);
    check("t6_nbytes", rx_q.size(), 30);
    check("t6_pend_end", Pend_Full, 0);
    check("t6_ovr_hold", OVR_CNT, 255);

    check("framing_errors", frame_err, 0);
    check("done_cycle_errors", bad_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/result_frame_tx.md
# result_frame_tx

Serial transmitter for the localisation result. It captures one snapshot of the result vectors P, Q and R, the quadrant code and the four status flags on every rising edge of Result_Ready. It serialises each snapshot as a fixed 15-byte UART frame (8N1, LSB first) on a single line. It sits downstream of the top-level result outputs and holds one snapshot in a pending buffer so that back-to-back results are not lost while a frame is on the line.

## Interface
- CLKS_PER_BIT, 434, Gbl_CLK cycles per UART bit; legal range 2..65535.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- Gbl_CLK  in  1  system clock; all logic is on the rising edge.
- RST_EX_N  in  1  reset; asynchronous assertion, active-low. One clock; reset is asynchronous and active-low.
- Result_Ready  in  1  result-valid level; capture happens on its rising edge only.
- P, Q, R  in  32 each  result values; sampled only at capture.
- Quadrent  in  2  quadrant code; sampled at capture.
- Flag_ERR, Flag_CNT, Flag_DIAG, Flag_MED  in  1 each  status flags; sampled at capture.
- TX_OUT  out  1  UART serial line; idle high.
- TX_BUSY  out  1  high while a frame is being shifted out (states START, DATA, STOP).
- Frame_Done  out  1  one-cycle pulse after the last stop bit of each frame.
- Pend_Full  out  1  pending buffer occupied.
- OVR_CNT  out  8  count of dropped snapshots; saturates at 255.

## Operation
- Edge detect: a register rr_q samples Result_Ready. A capture fires when Result_Ready=1 and rr_q=0. rr_q resets to 1, so a level already high at reset release does not fire.
- Snapshot: 104 bits, {flags, Quadrent, P, Q, R}.
- Status byte: {Flag_ERR, Flag_CNT, Flag_DIAG, Flag_MED, 2'b00, Quadrent}.
- Frame byte order:
  - byte 0: SYNC_BYTE
  - byte 1: status byte
  - bytes 2-5: P, MSB first
  - bytes 6-9: Q, MSB first
  - bytes 10-13: R, MSB first
  - byte 14: checksum, the XOR of bytes 1..13
- Checksum computation: may be accumulated byte by byte or computed combinationally from the active snapshot; only the transmitted value matters.
- Byte format: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts CLKS_PER_BIT cycles. There is no gap between bytes within a frame.
- FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE -> START on a capture, or when the pending buffer is valid.
  - START -> DATA after one bit time.
  - DATA -> STOP after 8 bit times.
  - STOP -> START when byte index < 14 (increment the index); STOP -> DONE when byte index = 14.
  - DONE -> START when the pending buffer is valid or a capture occurs in that cycle; otherwise DONE -> IDLE.
- Buffering:
  - A capture in IDLE or DONE loads the active register.
  - If the pending buffer is valid in DONE, the pending snapshot moves to active, and a capture in the same cycle goes into pending.
  - A capture in START, DATA or STOP loads pending if it is empty.
  - If pending is full, the new snapshot is dropped, OVR_CNT increments and the pending content is kept.
- Counter widths: baud counter is ceil(log2(CLKS_PER_BIT)) bits; bit index is 3 bits; byte index is 4 bits. All counters clear on reset.

## Timing
- Reset values: TX_OUT=1, TX_BUSY=0, Frame_Done=0, Pend_Full=0, OVR_CNT=0, state=IDLE, rr_q=1.
- Reset mid-frame: TX_OUT goes to 1 immediately (asynchronously), and both the active and pending snapshots are discarded.
- Latency: a capture at clock edge n in IDLE drives the start bit onto TX_OUT from edge n+1.
- Frame length: 150*CLKS_PER_BIT cycles in START/DATA/STOP.
- Frame_Done is high for the single DONE cycle; TX_OUT=1 and TX_BUSY=0 during that cycle.
- Back-to-back frames are separated by exactly one idle-high cycle (the DONE cycle).
- Inputs are sampled only at the capture edge. Changes to P/Q/R/flags after capture do not affect the frame in flight.
- Result_Ready held high produces exactly one capture. A new capture requires Result_Ready to return low for at least one cycle.

## Test plan
- CLKS_PER_BIT=4; P=1, Q=2, R=3, Quadrent=2'b10, Flag_DIAG=1, other flags 0; single Result_Ready pulse -> TX_OUT decodes as A5 22 00 00 00 01 00 00 00 02 00 00 00 03 22; start bit appears one cycle after the capture edge; Frame_Done pulses 601 cycles after the capture edge.
- Result_Ready held high for 1000 cycles -> exactly one frame is sent and OVR_CNT=0.
- Three captures during one frame: the first is in flight, the second goes to pending (Pend_Full=1), the third is dropped -> two frames are sent separated by one idle cycle, and OVR_CNT=1.
- Capture coincident with the DONE cycle while pending is valid -> the pending snapshot is sent next and the new capture is held in pending, then sent; OVR_CNT=0.
- RST_EX_N asserted during byte 7 -> TX_OUT=1 in the same cycle, Pend_Full=0 and no Frame_Done; after release, a fresh capture yields a complete correct frame.
- 300 captures with transmission continuously busy -> OVR_CNT saturates at 255.
